// File: rtl/sram_avalon_initiator_if.sv
// Command/response port and active-low SRAM bridge strobes for sram_avalon_initiator.
// The master modport is the initiator's view; slave is the view of whatever surrounds it.
interface sram_avalon_initiator_if #(
  parameter int DATA_BITS = 16,
  parameter int ADDR_BITS = 18
);
  localparam int BE_BITS = DATA_BITS / 8;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [ADDR_BITS-1:0] cmd_address;
  logic [DATA_BITS-1:0] cmd_writedata;
  logic [BE_BITS-1:0]   cmd_byteenable;
  logic                 rsp_valid;
  logic [DATA_BITS-1:0] rsp_readdata;
  logic                 busy;
  logic                 m_chipselect_n;
  logic                 m_read_n;
  logic                 m_write_n;
  logic [BE_BITS-1:0]   m_byteenable_n;
  logic [ADDR_BITS-1:0] m_address;
  logic [DATA_BITS-1:0] m_writedata;
  logic [DATA_BITS-1:0] m_readdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_writedata, cmd_byteenable, m_readdata,
    output cmd_ready, rsp_valid, rsp_readdata, busy,
           m_chipselect_n, m_read_n, m_write_n, m_byteenable_n, m_address, m_writedata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_writedata, cmd_byteenable, m_readdata,
    input  cmd_ready, rsp_valid, rsp_readdata, busy,
           m_chipselect_n, m_read_n, m_write_n, m_byteenable_n, m_address, m_writedata
  );
endinterface

// File: rtl/sram_avalon_initiator.sv
// Single-transaction initiator for the active-low SRAM bridge with timed strobes.
// Optional per-type access counters when SRAM_AVALON_INITIATOR_STATS_EN is defined.
//   state  | meaning
//   IDLE   | cmd_ready high, waiting for a command
//   ACCESS | chip select and read/write strobe low for WAIT_CYCLES cycles
//   HOLD   | strobes released, bus held; read response pulses here
//   TURN   | bus turnaround idle cycles before the next accept
module sram_avalon_initiator #(
  parameter int DATA_BITS   = 16,
  parameter int ADDR_BITS   = 18,
  parameter int WAIT_CYCLES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  sram_avalon_initiator_if.master bus
`ifdef SRAM_AVALON_INITIATOR_STATS_EN
  ,
  output logic [15:0] stat_reads,
  output logic [15:0] stat_writes
`endif
);

  localparam int BE_BITS  = DATA_BITS / 8;
  localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CNT_MAX  = (WAIT_EFF > TURN_CYCLES) ? WAIT_EFF : TURN_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int TURN_LD  = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD, TURN} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 is_write_q, is_write_d;
  logic                 cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic [BE_BITS-1:0]   be_n_q, be_n_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_write_d  = is_write_q;
    cs_n_d      = cs_n_q;
    rd_n_d      = rd_n_q;
    wr_n_d      = wr_n_q;
    be_n_d      = be_n_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.cmd_valid && ready_q) begin
          state_d    = ACCESS;
          cnt_d      = CNT_W'(WAIT_EFF - 1);
          ready_d    = 1'b0;
          busy_d     = 1'b1;
          is_write_d = bus.cmd_write;
          addr_d     = bus.cmd_address;
          wdata_d    = bus.cmd_writedata;
          be_n_d     = ~bus.cmd_byteenable;
          cs_n_d     = 1'b0;
          wr_n_d     = ~bus.cmd_write;
          rd_n_d     = bus.cmd_write;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cs_n_d  = 1'b1;
          rd_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          // read data is sampled on the edge that closes the last strobe cycle
          if (!is_write_q) begin
            rsp_valid_d = 1'b1;
            rdata_d     = bus.m_readdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (TURN_CYCLES == 0) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = TURN;
          cnt_d   = CNT_W'(TURN_LD);
        end
      end
      TURN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_write_q  <= 1'b0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      be_n_q      <= '1;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_write_q  <= is_write_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      be_n_q      <= be_n_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

`ifdef SRAM_AVALON_INITIATOR_STATS_EN
  logic enter_hold;
  assign enter_hold = (state_q == ACCESS) && (state_d == HOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_reads  <= '0;
      stat_writes <= '0;
    end else if (enter_hold) begin
      if (is_write_q) stat_writes <= stat_writes + 16'd1;
      else            stat_reads  <= stat_reads + 16'd1;
    end
  end
`endif

  assign bus.cmd_ready      = ready_q;
  assign bus.busy           = busy_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_readdata   = rdata_q;
  assign bus.m_chipselect_n = cs_n_q;
  assign bus.m_read_n       = rd_n_q;
  assign bus.m_write_n      = wr_n_q;
  assign bus.m_byteenable_n = be_n_q;
  assign bus.m_address      = addr_q;
  assign bus.m_writedata    = wdata_q;

endmodule

// File: doc/sram_avalon_initiator.md
Name: sram_avalon_initiator

Overview:
- Avalon-style master that issues single read/write transactions to the active-low SRAM slave bridge (chipselect_n/read_n/write_n/byteenable_n strobes).
- Accepts commands on a valid/ready port, runs a timed access with programmable wait states, and returns read data with a one-cycle valid pulse.
- Sits between on-chip logic (test engine, DMA, CPU shim) and the SRAM bridge.

Parameters:
- DATA_BITS, 16, data width; must be a multiple of 8.
- ADDR_BITS, 18, word address width.
- WAIT_CYCLES, 2, cycles the strobes stay asserted per access; a value of 0 is treated as 1.
- TURN_CYCLES, 1, idle cycles after each access before the next command is accepted; 0 is allowed.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_address  in  ADDR_BITS  word address.
- cmd_writedata  in  DATA_BITS  write data.
- cmd_byteenable  in  DATA_BITS/8  active-high byte lanes.
- rsp_valid  out  1  one-cycle pulse; rsp_readdata is valid.
- rsp_readdata  out  DATA_BITS  captured read data.
- busy  out  1  transaction in progress.
- m_chipselect_n  out  1  active-low chip select.
- m_read_n  out  1  active-low read strobe.
- m_write_n  out  1  active-low write strobe.
- m_byteenable_n  out  DATA_BITS/8  active-low byte lanes.
- m_address  out  ADDR_BITS  address to the slave.
- m_writedata  out  DATA_BITS  write data to the slave.
- m_readdata  in  DATA_BITS  read data from the slave.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high. Every output is registered.
- Reset values: m_chipselect_n=1, m_read_n=1, m_write_n=1, m_byteenable_n=all 1s, m_address=0, m_writedata=0, rsp_valid=0, rsp_readdata=0, cmd_ready=0, busy=0.
- cmd_ready rises on the first clk edge after reset is released.
- FSM states are IDLE, ACCESS, HOLD, TURN.
- IDLE:
  - cmd_ready=1.
  - Handshake completes when cmd_valid & cmd_ready on a rising edge (cycle T).
  - On that edge, latch address, writedata and ~byteenable onto the m_* outputs; set cmd_ready=0, busy=1; go to ACCESS.
- ACCESS, cycles T+1 .. T+WAIT_CYCLES:
  - m_chipselect_n=0, plus m_write_n=0 (write) or m_read_n=0 (read). Never both.
  - A wait counter counts WAIT_CYCLES cycles.
  - For a read, m_readdata is sampled on the clock edge that ends the last ACCESS cycle.
- HOLD, one cycle:
  - All strobes = 1; address, data and byte enables stay unchanged (hold time).
  - For a read, rsp_valid=1 for exactly this cycle with the captured data.
  - rsp_readdata then holds its value until the next read completes.
- TURN: TURN_CYCLES cycles, strobes deasserted; skipped when TURN_CYCLES=0.
- Return to IDLE: cmd_ready=1 and busy=0 in cycle T+WAIT_CYCLES+2+TURN_CYCLES.
- A write never produces rsp_valid.
- cmd_byteenable=0: the access still runs with m_byteenable_n all 1s; a read still returns rsp_valid.
- cmd_valid while not ready: ignored; the command must be held by the source.
- Reset mid-transaction: strobes deassert immediately and asynchronously, the transaction is dropped, and no rsp_valid is issued.
- Counter width is clog2(max(WAIT_CYCLES, TURN_CYCLES)+1). The counter must not wrap beyond its terminal count.

Optional Feature:
- Macro SRAM_AVALON_INITIATOR_STATS_EN.
- Defined: adds outputs stat_reads and stat_writes, 16 bits each.
  - Each increments on entry to HOLD for its transaction type and wraps 0xFFFF->0.
  - Both clear on reset.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Write test (WAIT=2, TURN=1): write addr 0x00123, data 0xBEEF, be=2'b11. Expect m_write_n=0 and m_chipselect_n=0 for exactly 2 cycles, m_byteenable_n=2'b00, address/data held through HOLD, no rsp_valid, cmd_ready back 5 cycles after accept.
- Read test: with the slave model returning 0xA55A at 0x3FFFF, read 0x3FFFF. Expect m_read_n low for 2 cycles, rsp_valid high for one cycle with rsp_readdata=0xA55A, m_write_n=1 throughout.
- Byte lanes: write be=2'b10 -> m_byteenable_n=2'b01. Write be=2'b00 -> cycle still runs with m_byteenable_n=2'b11.
- Back-to-back with cmd_valid held high, WAIT=1, TURN=0: write then read. Accepts are 3 cycles apart, strobes never overlap, and the HOLD cycle between accesses has all strobes deasserted.
- Reset during ACCESS of a read: strobes go to 1 in the same cycle as reset. After release, rsp_valid never pulses for the dropped read, and cmd_ready=1 after one clock.
- STATS_EN build: 3 writes and 2 reads -> stat_writes=3, stat_reads=2. Preload to 0xFFFF and issue one more write -> stat_writes wraps to 0.
